issue_pair_splitter: RTL and testbench
======================================

# issue_pair_splitter

Dual-issue pairing stage between the decode stage and the Execute pipeline register. Each cycle it receives the two decoded instructions (lane A older, lane B younger) and decides whether they may enter Execute together. On an intra-pair hazard it issues A alone, holds B, stalls decode for one cycle, then issues B. It also keeps issue and split counters for performance analysis.

## Interface
- PW, 160: width of the opaque per-lane decoded payload (ALU control, operand values, immediate, PC+4, ...), passed through unmodified.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- StallE  in  1  Execute register stall; freezes this block.
- FlushD  in  1  discard the decode-stage pair and any held instruction.
- ValidDA, ValidDB  in  1 each  lane carries a real instruction.
- RegWriteDA/DB, MemtoRegDA/DB, MemWriteDA/DB  in  1 each  decoded control.
- WriteRegDA/DB  in  5 each  destination register number.
- RsAddrDB, RtAddrDB  in  5 each  lane-B source register numbers.
- UsesRsDB, UsesRtDB  in  1 each  lane B actually reads rs/rt.
- PayloadDA/DB  in  PW each  decoded bundle.
- ValidEA, ValidEB  out  1 each  lane issued this cycle.
- RegWriteEA/EB, MemtoRegEA/EB, MemWriteEA/EB  out  1 each  control, forced 0 when the lane is invalid.
- WriteRegEA/EB  out  5 each; PayloadEA/EB  out  PW each.
- StallDOut  out  1  hold the decode register and fetch.
- IssueCount  out  32  instructions issued since reset.
- SplitCount  out  32  pairs split since reset.

## Operation
- FSM states: PASS, SPLIT. There is a hold register for lane B: control, WriteReg and payload.
- Conflict applies only when ValidDA and ValidDB are both 1. It is the OR of the following:
  - RAW: RegWriteDA, WriteRegDA≠0, and (UsesRsDB and RsAddrDB==WriteRegDA, or UsesRtDB and RtAddrDB==WriteRegDA).
  - WAW: RegWriteDA, RegWriteDB, WriteRegDA==WriteRegDB≠0.
  - Dual memory: (MemtoRegDA|MemWriteDA) and (MemtoRegDB|MemWriteDB).
- PASS, no conflict:
  - Lanes pass straight through: EA←DA, EB←DB.
  - StallDOut=0.
- PASS, conflict:
  - Lane A issues, ValidEB=0.
  - StallDOut=1.
  - Lane B is captured into the hold register.
  - Next state is SPLIT; SplitCount increments.
- SPLIT:
  - Output lane A carries the held B. ValidEA=1, ValidEB=0.
  - StallDOut=0, so decode advances at the end of the cycle.
  - Next state is PASS.
- Invalid lanes present all control outputs 0. Their payload and WriteReg values are don't-care but deterministic, driven from the input.
- Only ValidDB=1 (A empty): B issues on lane B, with no conflict check.
- IssueCount increments by ValidEA+ValidEB in every non-stalled cycle. Counters wrap modulo 2^32.

## Timing
- Pass-through is combinational: inputs to E outputs in the same cycle, with 0 cycles of latency. The Execute register provides the pipeline register.
- A split pair occupies 2 cycles: A in cycle n, B in cycle n+1.
- Decode loses exactly 1 cycle per split.
- StallE=1 has the following effects:
  - State, hold register and counters are frozen.
  - StallDOut=1.
  - Outputs keep their combinational values; the Execute register ignores them.
- FlushD=1, when StallE=0, has the following effects:
  - Next state is PASS and the hold register is invalidated.
  - Counters do not count the flushed cycle's outputs.
  - StallDOut=0.
- FlushD and StallE both 1: the flush takes priority and the state returns to PASS.
- Reset (including mid-SPLIT) leaves the block as follows:
  - State PASS, hold register cleared.
  - IssueCount=SplitCount=0.
  - All E outputs have Valid and control at 0, and StallDOut=0, while reset is high.
- A conflicting pair arriving in SPLIT cannot occur, because decode is held. If a new pair does appear, it is evaluated only after returning to PASS.

## Test plan
- Independent pair: A `addu $3,$1,$2`, B `addu $6,$4,$5` → both valid in the same cycle; IssueCount +2; SplitCount 0; StallDOut 0.
- RAW: A writes $3, B reads rs=$3 → cycle n: EA=A, ValidEB=0, StallDOut=1; cycle n+1: EA=held B, StallDOut=0; SplitCount=1, IssueCount=2.
- RAW on $0 (WriteRegDA=0, B reads $0) → no split. Also: WAW on $7 splits; lw followed by sw splits.
- StallE asserted in the SPLIT cycle for 3 cycles → state stays SPLIT, StallDOut=1 for all 3 cycles; held B issues in the first cycle after StallE drops; IssueCount unchanged while stalled.
- FlushD in the SPLIT cycle → held B is never issued; state returns to PASS; SplitCount keeps its earlier increment; IssueCount excludes B.
- Reset asserted while in SPLIT with counters at 5 and 1 → next cycle shows state PASS, counters 0, and all Valid and control outputs 0.

Source files
------------

// File: rtl/issue_pair_splitter.sv
// issue_pair_splitter
// Dual-issue pairing stage between Decode and the Execute pipeline register.
// Lane A is the older instruction and lane B the younger. If lane B depends on
// lane A (RAW), both write the same register (WAW), or both access memory,
// the pair is split: A issues alone while decode is stalled, B is parked in a
// hold register, and B issues on lane A in the following cycle. Pass-through
// is purely combinational; the Execute register downstream is the pipeline
// register. Issue and split counters are kept for performance analysis.

module issue_pair_splitter #(
  parameter int PW = 160
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallE,
  input  logic          FlushD,
  input  logic          ValidDA,
  input  logic          ValidDB,
  input  logic          RegWriteDA,
  input  logic          RegWriteDB,
  input  logic          MemtoRegDA,
  input  logic          MemtoRegDB,
  input  logic          MemWriteDA,
  input  logic          MemWriteDB,
  input  logic [4:0]    WriteRegDA,
  input  logic [4:0]    WriteRegDB,
  input  logic [4:0]    RsAddrDB,
  input  logic [4:0]    RtAddrDB,
  input  logic          UsesRsDB,
  input  logic          UsesRtDB,
  input  logic [PW-1:0] PayloadDA,
  input  logic [PW-1:0] PayloadDB,
  output logic          ValidEA,
  output logic          ValidEB,
  output logic          RegWriteEA,
  output logic          RegWriteEB,
  output logic          MemtoRegEA,
  output logic          MemtoRegEB,
  output logic          MemWriteEA,
  output logic          MemWriteEB,
  output logic [4:0]    WriteRegEA,
  output logic [4:0]    WriteRegEB,
  output logic [PW-1:0] PayloadEA,
  output logic [PW-1:0] PayloadEB,
  output logic          StallDOut,
  output logic [31:0]   IssueCount,
  output logic [31:0]   SplitCount
);

  typedef enum logic {
    PASS  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  // Decoded control bits that travel with an instruction.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } ctrl_t;

  state_e         state_q;
  logic           hold_valid_q;
  ctrl_t          hold_ctrl_q;
  logic [4:0]     hold_wreg_q;
  logic [PW-1:0]  hold_payload_q;
  logic [31:0]    issue_count_q;
  logic [31:0]    split_count_q;

  ctrl_t          ctrl_da;
  ctrl_t          ctrl_db;
  ctrl_t          ctrl_a_src;

  logic           raw_hazard;
  logic           waw_hazard;
  logic           mem_hazard;
  logic           conflict;

  logic           issue_a;
  logic           issue_b;
  logic           sel_hold;
  logic           split_stall;
  logic [31:0]    issue_inc;

  assign ctrl_da = '{reg_write: RegWriteDA, mem_to_reg: MemtoRegDA, mem_write: MemWriteDA};
  assign ctrl_db = '{reg_write: RegWriteDB, mem_to_reg: MemtoRegDB, mem_write: MemWriteDB};

  // Intra-pair hazard detection; writes to $0 never create a RAW/WAW hazard.
  always_comb begin
    raw_hazard = RegWriteDA && (WriteRegDA != 5'd0) &&
                 ((UsesRsDB && (RsAddrDB == WriteRegDA)) ||
                  (UsesRtDB && (RtAddrDB == WriteRegDA)));
    waw_hazard = RegWriteDA && RegWriteDB && (WriteRegDA == WriteRegDB) &&
                 (WriteRegDA != 5'd0);
    mem_hazard = (MemtoRegDA || MemWriteDA) && (MemtoRegDB || MemWriteDB);
    conflict   = ValidDA && ValidDB && (raw_hazard || waw_hazard || mem_hazard);
  end

  // Issue decision: which lanes go to Execute this cycle and whether to stall.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else leaves a value unassigned and infers a latch.
    issue_a     = 1'b0;
    issue_b     = 1'b0;
    sel_hold    = 1'b0;
    split_stall = 1'b0;
    if (!reset) begin
      if (state_q == SPLIT) begin
        // Held B leaves on lane A; any new decode pair waits for PASS.
        issue_a  = hold_valid_q;
        sel_hold = 1'b1;
      end else begin
        issue_a     = ValidDA;
        issue_b     = ValidDB && !conflict;
        split_stall = conflict;
      end
      // A flushed cycle issues nothing, including a held B.
      if (FlushD) begin
        issue_a     = 1'b0;
        issue_b     = 1'b0;
        split_stall = 1'b0;
      end
    end
  end

  assign ctrl_a_src = sel_hold ? hold_ctrl_q : ctrl_da;

  // Output lanes: control forced to 0 on an invalid lane, data always driven.
  always_comb begin
    ValidEA    = issue_a;
    RegWriteEA = issue_a && ctrl_a_src.reg_write;
    MemtoRegEA = issue_a && ctrl_a_src.mem_to_reg;
    MemWriteEA = issue_a && ctrl_a_src.mem_write;
    WriteRegEA = sel_hold ? hold_wreg_q : WriteRegDA;
    PayloadEA  = sel_hold ? hold_payload_q : PayloadDA;

    ValidEB    = issue_b;
    RegWriteEB = issue_b && RegWriteDB;
    MemtoRegEB = issue_b && MemtoRegDB;
    MemWriteEB = issue_b && MemWriteDB;
    WriteRegEB = WriteRegDB;
    PayloadEB  = PayloadDB;

    // Flush wins over every stall source; reset releases decode.
    StallDOut  = !reset && !FlushD && (StallE || split_stall);
  end

  assign issue_inc  = {31'd0, issue_a} + {31'd0, issue_b};
  assign IssueCount = issue_count_q;
  assign SplitCount = split_count_q;

  // State, hold register and counters; flush beats stall, stall freezes all.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    if (reset) begin
      state_q        <= PASS;
      hold_valid_q   <= 1'b0;
      // NOTE: the whole hold register, payload included, is cleared on reset
      // so a stale lane-B bundle can never resurface after reset.
      hold_ctrl_q    <= '0;
      hold_wreg_q    <= 5'd0;
      hold_payload_q <= '0;
      issue_count_q  <= 32'd0;
      split_count_q  <= 32'd0;
    end else if (FlushD) begin
      state_q      <= PASS;
      hold_valid_q <= 1'b0;
    end else if (!StallE) begin
      issue_count_q <= issue_count_q + issue_inc;
      case (state_q)
        PASS: begin
          if (conflict) begin
            state_q        <= SPLIT;
            hold_valid_q   <= 1'b1;
            hold_ctrl_q    <= ctrl_db;
            hold_wreg_q    <= WriteRegDB;
            hold_payload_q <= PayloadDB;
            split_count_q  <= split_count_q + 32'd1;
          end
        end
        SPLIT: begin
          state_q      <= PASS;
          hold_valid_q <= 1'b0;
        end
        default: state_q <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_pair_splitter.sv
// Directed testbench for issue_pair_splitter. Inputs change on the falling
// edge; combinational outputs are sampled 1 time unit later, and registered
// counters are read one falling edge after the rising edge that updates them.

module tb_issue_pair_splitter;

  localparam int PW = 160;
  localparam logic [PW-1:0] PA = 160'h1111_0000_0000_0000_0000_0000_0000_0000_0000_AAAA;
  localparam logic [PW-1:0] PB = 160'h2222_0000_0000_0000_0000_0000_0000_0000_0000_BBBB;

  logic          clk = 1'b0;
  logic          reset;
  logic          StallE, FlushD;
  logic          ValidDA, ValidDB;
  logic          RegWriteDA, RegWriteDB, MemtoRegDA, MemtoRegDB, MemWriteDA, MemWriteDB;
  logic [4:0]    WriteRegDA, WriteRegDB, RsAddrDB, RtAddrDB;
  logic          UsesRsDB, UsesRtDB;
  logic [PW-1:0] PayloadDA, PayloadDB;
  logic          ValidEA, ValidEB;
  logic          RegWriteEA, RegWriteEB, MemtoRegEA, MemtoRegEB, MemWriteEA, MemWriteEB;
  logic [4:0]    WriteRegEA, WriteRegEB;
  logic [PW-1:0] PayloadEA, PayloadEB;
  logic          StallDOut;
  logic [31:0]   IssueCount, SplitCount;

  int total;
  int passed;

  issue_pair_splitter #(.PW(PW)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushD(FlushD),
    .ValidDA(ValidDA), .ValidDB(ValidDB),
    .RegWriteDA(RegWriteDA), .RegWriteDB(RegWriteDB),
    .MemtoRegDA(MemtoRegDA), .MemtoRegDB(MemtoRegDB),
    .MemWriteDA(MemWriteDA), .MemWriteDB(MemWriteDB),
    .WriteRegDA(WriteRegDA), .WriteRegDB(WriteRegDB),
    .RsAddrDB(RsAddrDB), .RtAddrDB(RtAddrDB),
    .UsesRsDB(UsesRsDB), .UsesRtDB(UsesRtDB),
    .PayloadDA(PayloadDA), .PayloadDB(PayloadDB),
    .ValidEA(ValidEA), .ValidEB(ValidEB),
    .RegWriteEA(RegWriteEA), .RegWriteEB(RegWriteEB),
    .MemtoRegEA(MemtoRegEA), .MemtoRegEB(MemtoRegEB),
    .MemWriteEA(MemWriteEA), .MemWriteEB(MemWriteEB),
    .WriteRegEA(WriteRegEA), .WriteRegEB(WriteRegEB),
    .PayloadEA(PayloadEA), .PayloadEB(PayloadEB),
    .StallDOut(StallDOut), .IssueCount(IssueCount), .SplitCount(SplitCount)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    StallE = 0; FlushD = 0; ValidDA = 0; ValidDB = 0;
    RegWriteDA = 0; RegWriteDB = 0; MemtoRegDA = 0; MemtoRegDB = 0;
    MemWriteDA = 0; MemWriteDB = 0; WriteRegDA = 0; WriteRegDB = 0;
    RsAddrDB = 0; RtAddrDB = 0; UsesRsDB = 0; UsesRtDB = 0;
    PayloadDA = '0; PayloadDB = '0;
  endtask

  task automatic set_a(input logic rw, input logic m2r, input logic mw,
                       input logic [4:0] wr, input logic [PW-1:0] pl);
    ValidDA = 1; RegWriteDA = rw; MemtoRegDA = m2r; MemWriteDA = mw;
    WriteRegDA = wr; PayloadDA = pl;
  endtask

  task automatic set_b(input logic rw, input logic m2r, input logic mw,
                       input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [PW-1:0] pl);
    ValidDB = 1; RegWriteDB = rw; MemtoRegDB = m2r; MemWriteDB = mw;
    WriteRegDB = wr; RsAddrDB = rs; RtAddrDB = rt; UsesRsDB = urs; UsesRtDB = urt;
    PayloadDB = pl;
  endtask

  // Advance one full cycle and land 1 unit after the falling edge.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    set_a(1, 0, 0, 5'd3, PA);
    set_b(1, 0, 0, 5'd6, 5'd3, 5'd5, 1, 1, PB);
    next_cycle();
    next_cycle();
    total++; if (ValidEA !== 1'b0) $display("FAIL reset_vea got %0b exp 0", ValidEA); else passed++;
    total++; if (ValidEB !== 1'b0) $display("FAIL reset_veb got %0b exp 0", ValidEB); else passed++;
    total++; if (RegWriteEA !== 1'b0) $display("FAIL reset_rwea got %0b exp 0", RegWriteEA); else passed++;
    total++; if (StallDOut !== 1'b0) $display("FAIL reset_stall got %0b exp 0", StallDOut); else passed++;
    total++; if (IssueCount !== 32'd0) $display("FAIL reset_issue got %0d exp 0", IssueCount); else passed++;
    total++; if (SplitCount !== 32'd0) $display("FAIL reset_split got %0d exp 0", SplitCount); else passed++;
    reset = 0;
    clear_inputs();
    next_cycle();
  endtask

  // addu $3,$1,$2 paired with addu $6,$4,$5.
  task automatic test_independent();
    set_a(1, 0, 0, 5'd3, PA);
    set_b(1, 0, 0, 5'd6, 5'd4, 5'd5, 1, 1, PB);
    #1;
    total++; if (ValidEA !== 1'b1) $display("FAIL indep_vea got %0b exp 1", ValidEA); else passed++;
    total++; if (ValidEB !== 1'b1) $display("FAIL indep_veb got %0b exp 1", ValidEB); else passed++;
    total++; if (WriteRegEA !== 5'd3) $display("FAIL indep_wrea got %0d exp 3", WriteRegEA); else passed++;
    total++; if (WriteRegEB !== 5'd6) $display("FAIL indep_wreb got %0d exp 6", WriteRegEB); else passed++;
    total++; if (PayloadEB !== PB) $display("FAIL indep_pleb got %h exp %h", PayloadEB, PB); else passed++;
    total++; if (RegWriteEB !== 1'b1) $display("FAIL indep_rweb got %0b exp 1", RegWriteEB); else passed++;
    total++; if (StallDOut !== 1'b0) $display("FAIL indep_stall got %0b exp 0", StallDOut); else passed++;
    next_cycle();
    clear_inputs();
    total++; if (IssueCount !== 32'd2) $display("FAIL indep_issue got %0d exp 2", IssueCount); else passed++;
    total++; if (SplitCount !== 32'd0) $display("FAIL indep_split got %0d exp 0", SplitCount); else passed++;
  endtask

  // A writes $3, B reads rs=$3: A alone, then held B on lane A.
  task automatic test_raw();
    set_a(1, 0, 0, 5'd3, PA);
    set_b(1, 0, 0, 5'd6, 5'd3, 5'd5, 1, 1, PB);
    #1;
    total++; if (ValidEA !== 1'b1) $display("FAIL raw_n_vea got %0b exp 1", ValidEA); else passed++;
    total++; if (PayloadEA !== PA) $display("FAIL raw_n_plea got %h exp %h", PayloadEA, PA); else passed++;
    total++; if (ValidEB !== 1'b0) $display("FAIL raw_n_veb got %0b exp 0", ValidEB); else passed++;
    total++; if (RegWriteEB !== 1'b0) $display("FAIL raw_n_rweb got %0b exp 0", RegWriteEB); else passed++;
    total++; if (StallDOut !== 1'b1) $display("FAIL raw_n_stall got %0b exp 1", StallDOut); else passed++;
    next_cycle();
    total++; if (ValidEA !== 1'b1) $display("FAIL raw_n1_vea got %0b exp 1", ValidEA); else passed++;
    total++; if (PayloadEA !== PB) $display("FAIL raw_n1_plea got %h exp %h", PayloadEA, PB); else passed++;
    total++; if (WriteRegEA !== 5'd6) $display("FAIL raw_n1_wrea got %0d exp 6", WriteRegEA); else passed++;
    total++; if (RegWriteEA !== 1'b1) $display("FAIL raw_n1_rwea got %0b exp 1", RegWriteEA); else passed++;
    total++; if (ValidEB !== 1'b0) $display("FAIL raw_n1_veb got %0b exp 0", ValidEB); else passed++;
    total++; if (StallDOut !== 1'b0) $display("FAIL raw_n1_stall got %0b exp 0", StallDOut); else passed++;
    next_cycle();
    clear_inputs();
    total++; if (IssueCount !== 32'd4) $display("FAIL raw_issue got %0d exp 4", IssueCount); else passed++;
    total++; if (SplitCount !== 32'd1) $display("FAIL raw_split got %0d exp 1", SplitCount); else passed++;
  endtask

  // A "writes" $0 and B reads $0: no hazard.
  task automatic test_zero_reg();
    set_a(1, 0, 0, 5'd0, PA);
    set_b(1, 0, 0, 5'd6, 5'd0, 5'd5, 1, 1, PB);
    #1;
    total++; if (ValidEB !== 1'b1) $display("FAIL zero_veb got %0b exp 1", ValidEB); else passed++;
    total++; if (StallDOut !== 1'b0) $display("FAIL zero_stall got %0b exp 0", StallDOut); else passed++;
    next_cycle();
    clear_inputs();
    total++; if (IssueCount !== 32'd6) $display("FAIL zero_issue got %0d exp 6", IssueCount); else passed++;
  endtask

  // Both lanes write $7.
  task automatic test_waw();
    set_a(1, 0, 0, 5'd7, PA);
    set_b(1, 0, 0, 5'd7, 5'd1, 5'd2, 1, 1, PB);
    #1;
    total++; if (StallDOut !== 1'b1) $display("FAIL waw_stall got %0b exp 1", StallDOut); else passed++;
    total++; if (ValidEB !== 1'b0) $display("FAIL waw_veb got %0b exp 0", ValidEB); else passed++;
    next_cycle();
    total++; if (PayloadEA !== PB) $display("FAIL waw_n1_plea got %h exp %h", PayloadEA, PB); else passed++;
    next_cycle();
    clear_inputs();
    total++; if (IssueCount !== 32'd8) $display("FAIL waw_issue got %0d exp 8", IssueCount); else passed++;
    total++; if (SplitCount !== 32'd2) $display("FAIL waw_split got %0d exp 2", SplitCount); else passed++;
  endtask

  // lw $8,0($29) followed by sw $9,4($29).
  task automatic test_dual_mem();
    set_a(1, 1, 0, 5'd8, PA);
    set_b(0, 0, 1, 5'd9, 5'd29, 5'd9, 1, 1, PB);
    #1;
    total++; if (StallDOut !== 1'b1) $display("FAIL mem_stall got %0b exp 1", StallDOut); else passed++;
    total++; if (MemtoRegEA !== 1'b1) $display("FAIL mem_m2rea got %0b exp 1", MemtoRegEA); else passed++;
    total++; if (MemWriteEB !== 1'b0) $display("FAIL mem_mweb got %0b exp 0", MemWriteEB); else passed++;
    next_cycle();
    total++; if (MemWriteEA !== 1'b1) $display("FAIL mem_n1_mwea got %0b exp 1", MemWriteEA); else passed++;
    total++; if (MemtoRegEA !== 1'b0) $display("FAIL mem_n1_m2rea got %0b exp 0", MemtoRegEA); else passed++;
    total++; if (RegWriteEA !== 1'b0) $display("FAIL mem_n1_rwea got %0b exp 0", RegWriteEA); else passed++;
    next_cycle();
    clear_inputs();
    total++; if (IssueCount !== 32'd10) $display("FAIL mem_issue got %0d exp 10", IssueCount); else passed++;
    total++; if (SplitCount !== 32'd3) $display("FAIL mem_split got %0d exp 3", SplitCount); else passed++;
  endtask

  // Only lane B valid: hazard fields on A are ignored and A control is 0.
  task automatic test_lane_b_only();
    set_a(1, 1, 0, 5'd3, PA);
    ValidDA = 0;
    set_b(1, 1, 0, 5'd3, 5'd3, 5'd3, 1, 1, PB);
    #1;
    total++; if (ValidEB !== 1'b1) $display("FAIL bonly_veb got %0b exp 1", ValidEB); else passed++;
    total++; if (ValidEA !== 1'b0) $display("FAIL bonly_vea got %0b exp 0", ValidEA); else passed++;
    total++; if (RegWriteEA !== 1'b0) $display("FAIL bonly_rwea got %0b exp 0", RegWriteEA); else passed++;
    total++; if (StallDOut !== 1'b0) $display("FAIL bonly_stall got %0b exp 0", StallDOut); else passed++;
    next_cycle();
    clear_inputs();
    total++; if (IssueCount !== 32'd11) $display("FAIL bonly_issue got %0d exp 11", IssueCount); else passed++;
  endtask

  // StallE held for 3 cycles during SPLIT.
  task automatic test_stall_in_split();
    set_a(1, 0, 0, 5'd3, PA);
    set_b(1, 0, 0, 5'd6, 5'd5, 5'd3, 0, 1, PB);
    next_cycle();
    StallE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (StallDOut !== 1'b1) $display("FAIL stall_c%0d_stall got %0b exp 1", i, StallDOut); else passed++;
      next_cycle();
    end
    total++; if (IssueCount !== 32'd12) $display("FAIL stall_frozen_issue got %0d exp 12", IssueCount); else passed++;
    total++; if (SplitCount !== 32'd4) $display("FAIL stall_frozen_split got %0d exp 4", SplitCount); else passed++;
    StallE = 0;
    #1;
    total++; if (ValidEA !== 1'b1) $display("FAIL stall_rel_vea got %0b exp 1", ValidEA); else passed++;
    total++; if (PayloadEA !== PB) $display("FAIL stall_rel_plea got %h exp %h", PayloadEA, PB); else passed++;
    total++; if (StallDOut !== 1'b0) $display("FAIL stall_rel_stall got %0b exp 0", StallDOut); else passed++;
    next_cycle();
    clear_inputs();
    total++; if (IssueCount !== 32'd13) $display("FAIL stall_issue got %0d exp 13", IssueCount); else passed++;
  endtask

  // FlushD in the SPLIT cycle discards held B.
  task automatic test_flush_in_split();
    set_a(1, 0, 0, 5'd4, PA);
    set_b(1, 0, 0, 5'd9, 5'd4, 5'd1, 1, 0, PB);
    next_cycle();
    FlushD = 1;
    #1;
    total++; if (StallDOut !== 1'b0) $display("FAIL flush_stall got %0b exp 0", StallDOut); else passed++;
    next_cycle();
    clear_inputs();
    set_a(1, 0, 0, 5'd3, PA);
    set_b(1, 0, 0, 5'd6, 5'd4, 5'd5, 1, 1, PB);
    #1;
    total++; if (PayloadEA !== PA) $display("FAIL flush_pass_plea got %h exp %h", PayloadEA, PA); else passed++;
    total++; if (ValidEB !== 1'b1) $display("FAIL flush_pass_veb got %0b exp 1", ValidEB); else passed++;
    total++; if (IssueCount !== 32'd14) $display("FAIL flush_issue got %0d exp 14", IssueCount); else passed++;
    total++; if (SplitCount !== 32'd5) $display("FAIL flush_split got %0d exp 5", SplitCount); else passed++;
    next_cycle();
    clear_inputs();
    total++; if (IssueCount !== 32'd16) $display("FAIL flush_after_issue got %0d exp 16", IssueCount); else passed++;
  endtask

  // Reset while in SPLIT with counters at 5 and 1.
  task automatic test_reset_mid_split();
    reset = 1;
    next_cycle();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      set_a(1, 0, 0, 5'd3, PA);
      set_b(1, 0, 0, 5'd6, 5'd4, 5'd5, 1, 1, PB);
      next_cycle();
    end
    set_b(1, 0, 0, 5'd6, 5'd3, 5'd5, 1, 1, PB);
    next_cycle();
    total++; if (IssueCount !== 32'd5) $display("FAIL rms_pre_issue got %0d exp 5", IssueCount); else passed++;
    total++; if (SplitCount !== 32'd1) $display("FAIL rms_pre_split got %0d exp 1", SplitCount); else passed++;
    reset = 1;
    #1;
    total++; if (ValidEA !== 1'b0) $display("FAIL rms_vea got %0b exp 0", ValidEA); else passed++;
    total++; if (RegWriteEA !== 1'b0) $display("FAIL rms_rwea got %0b exp 0", RegWriteEA); else passed++;
    total++; if (StallDOut !== 1'b0) $display("FAIL rms_stall got %0b exp 0", StallDOut); else passed++;
    next_cycle();
    total++; if (IssueCount !== 32'd0) $display("FAIL rms_issue got %0d exp 0", IssueCount); else passed++;
    total++; if (SplitCount !== 32'd0) $display("FAIL rms_split got %0d exp 0", SplitCount); else passed++;
    reset = 0;
    #1;
    // Back in PASS: the same conflicting pair now issues A and stalls decode.
    total++; if (PayloadEA !== PA) $display("FAIL rms_pass_plea got %h exp %h", PayloadEA, PA); else passed++;
    total++; if (StallDOut !== 1'b1) $display("FAIL rms_pass_stall got %0b exp 1", StallDOut); else passed++;
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    clear_inputs();
    reset = 1;
    test_reset();
    test_independent();
    test_raw();
    test_zero_reg();
    test_waw();
    test_dual_mem();
    test_lane_b_only();
    test_stall_in_split();
    test_flush_in_split();
    test_reset_mid_split();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
